// File: rtl/mic_pitch_scorer.sv
// mic_pitch_scorer: hysteretic zero-crossing pitch detector and windowed note scorer.
// Optional build macro MIC_PITCH_SCORER_STREAK_EN adds a consecutive-pass streak
// output and a double increment once the streak reaches 4.
module mic_pitch_scorer #(
    parameter int unsigned SAMPLE_W       = 16,
    parameter int unsigned PERIOD_W       = 12,
    parameter int unsigned HYST           = 64,
    parameter int unsigned TOL            = 1,
    parameter int unsigned WINDOW_SAMPLES = 1024,
    parameter int unsigned HIT_THRESH     = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] sample,
    input  logic        [PERIOD_W-1:0] target_period,
    input  logic                       score_clear,
    output logic        [31:0]         counter_val,
    output logic        [PERIOD_W-1:0] period_out,
    output logic                       period_valid,
    output logic                       hit,
`ifdef MIC_PITCH_SCORER_STREAK_EN
    output logic        [7:0]          streak,
`endif
    output logic                       window_done
);

    localparam int unsigned WCNT_W = $clog2(WINDOW_SAMPLES) + 1;
    localparam int unsigned HCNT_W = $clog2(WINDOW_SAMPLES) + 1;

    localparam logic signed [SAMPLE_W-1:0] HYST_POS = SAMPLE_W'(HYST);
    localparam logic signed [SAMPLE_W-1:0] HYST_NEG = -HYST_POS;
    localparam logic [PERIOD_W-1:0]        CNT_LAST = PERIOD_W'((2 ** PERIOD_W) - 2);
    localparam logic [PERIOD_W:0]          TOL_V    = (PERIOD_W + 1)'(TOL);
    localparam logic [WCNT_W-1:0]          WIN_LAST = WCNT_W'(WINDOW_SAMPLES - 1);
    localparam logic [HCNT_W:0]            THRESH_V = (HCNT_W + 1)'(HIT_THRESH);

    typedef enum logic [1:0] {IDLE, ARMED, MEASURE} state_t;

    state_t              state, state_next;
    logic                pos_q;
    logic [PERIOD_W-1:0] tgt_q;
    logic [PERIOD_W-1:0] cnt;
    logic [WCNT_W-1:0]   wcnt;
    logic [HCNT_W-1:0]   hit_count;

    logic                tgt_chg_c, rise_c, hit_c, win_end_c, pass_c;
    logic [PERIOD_W-1:0] meas_c;
    logic [PERIOD_W:0]   diff_c, absd_c;
    logic [HCNT_W:0]     hsum_c;
    logic [HCNT_W-1:0]   hsat_c;
    logic [1:0]          inc_c;
    logic [32:0]         csum_c;

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state and combinational datapath decisions
    always_comb begin
        state_next = state;
        tgt_chg_c  = (target_period != tgt_q);
        rise_c     = sample_valid && !pos_q && (sample > HYST_POS);
        meas_c     = cnt + PERIOD_W'(1);
        diff_c     = {1'b0, meas_c} - {1'b0, tgt_q};
        absd_c     = diff_c[PERIOD_W] ? ((PERIOD_W + 1)'(0) - diff_c) : diff_c;
        hit_c      = (state == MEASURE) && rise_c && (tgt_q != '0) && (absd_c <= TOL_V);
        win_end_c  = (state != IDLE) && sample_valid && !tgt_chg_c && (wcnt == WIN_LAST);
        hsum_c     = {1'b0, hit_count} + (HCNT_W + 1)'(hit_c);
        hsat_c     = hsum_c[HCNT_W] ? '1 : hsum_c[HCNT_W-1:0];
        pass_c     = win_end_c && (hsum_c >= THRESH_V);
`ifdef MIC_PITCH_SCORER_STREAK_EN
        inc_c      = (streak >= 8'd4) ? 2'd2 : 2'd1;
`else
        inc_c      = 2'd1;
`endif
        csum_c     = {1'b0, counter_val} + 33'(inc_c);

        if (tgt_chg_c) begin
            state_next = (target_period == '0) ? IDLE : ARMED;
        end else begin
            case (state)
                IDLE:    state_next = IDLE;
                ARMED:   if (rise_c) state_next = MEASURE;
                MEASURE: if (sample_valid && !rise_c && (cnt == CNT_LAST)) state_next = ARMED;
                default: state_next = IDLE;
            endcase
        end
    end

    // Polarity, period measurement, window accounting and score counter
    always_ff @(posedge clock) begin
        if (reset) begin
            pos_q        <= 1'b0;
            tgt_q        <= '0;
            cnt          <= '0;
            wcnt         <= '0;
            hit_count    <= '0;
            counter_val  <= '0;
            period_out   <= '0;
            period_valid <= 1'b0;
            hit          <= 1'b0;
            window_done  <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            hit          <= 1'b0;
            window_done  <= win_end_c;
            tgt_q        <= target_period;

            if (sample_valid) begin
                if (sample > HYST_POS)      pos_q <= 1'b1;
                else if (sample < HYST_NEG) pos_q <= 1'b0;
            end

            if (tgt_chg_c) begin
                cnt       <= '0;
                wcnt      <= '0;
                hit_count <= '0;
            end else if (sample_valid && (state != IDLE)) begin
                if (rise_c) begin
                    cnt <= '0;
                    if (state == MEASURE) begin
                        period_out   <= meas_c;
                        period_valid <= 1'b1;
                        hit          <= hit_c;
                    end
                end else if (state == MEASURE) begin
                    // Give up on this period just before the counter would wrap
                    cnt <= (cnt == CNT_LAST) ? '0 : meas_c;
                end

                if (win_end_c) begin
                    wcnt      <= '0;
                    hit_count <= '0;
                end else begin
                    wcnt      <= wcnt + WCNT_W'(1);
                    hit_count <= hsat_c;
                end
            end

            if (score_clear)  counter_val <= '0;
            else if (pass_c)  counter_val <= csum_c[32] ? 32'hFFFF_FFFF : csum_c[31:0];
        end
    end

`ifdef MIC_PITCH_SCORER_STREAK_EN
    // Consecutive passing-window streak
    always_ff @(posedge clock) begin
        if (reset || score_clear || tgt_chg_c) begin
            streak <= '0;
        end else if (win_end_c) begin
            if (!pass_c)                streak <= '0;
            else if (streak != 8'hFF)   streak <= streak + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mic_pitch_scorer.sv
// Directed self-checking bench for mic_pitch_scorer (default parameters).
module tb_mic_pitch_scorer;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               sample_valid = 1'b0;
    logic signed [15:0] sample = '0;
    logic        [11:0] target_period = '0;
    logic               score_clear = 1'b0;
    logic        [31:0] counter_val;
    logic        [11:0] period_out;
    logic               period_valid;
    logic               hit;
    logic               window_done;
`ifdef MIC_PITCH_SCORER_STREAK_EN
    logic        [7:0]  streak;
`endif

    int tests = 0;
    int fails = 0;
    int k = 0;

    always #5 clock = ~clock;

    mic_pitch_scorer dut (
        .clock        (clock),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample       (sample),
        .target_period(target_period),
        .score_clear  (score_clear),
        .counter_val  (counter_val),
        .period_out   (period_out),
        .period_valid (period_valid),
        .hit          (hit),
`ifdef MIC_PITCH_SCORER_STREAK_EN
        .streak       (streak),
`endif
        .window_done  (window_done)
    );

    function automatic logic signed [15:0] sq(input int j);
        return ((j % 8) < 4) ? 16'sd1000 : -16'sd1000;
    endfunction

    function automatic logic signed [15:0] quiet(input int j);
        logic signed [15:0] tbl [8];
        tbl = '{16'sd0, 16'sd35, 16'sd50, 16'sd35, 16'sd0, -16'sd35, -16'sd50, -16'sd35};
        return tbl[j % 8];
    endfunction

    task automatic drive(input logic signed [15:0] s, input logic v, input logic clr);
        @(negedge clock);
        sample = s;
        sample_valid = v;
        score_clear = clr;
        @(posedge clock);
        #1;
    endtask

    task automatic set_target(input logic [11:0] t);
        @(negedge clock);
        target_period = t;
        sample_valid = 1'b0;
        score_clear = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        target_period = '0;
        for (int j = 0; j < 3; j++) begin
            drive(sq(j), 1'b1, 1'b0);
            tests++;
            if ({counter_val, period_out, period_valid, hit, window_done} !== '0) begin
                fails++;
                $display("FAIL reset_outputs cyc %0d: cv=%0d po=%0d pv=%b hit=%b wd=%b, want all 0",
                         j, counter_val, period_out, period_valid, hit, window_done);
            end
        end
        reset = 1'b0;
        for (int j = 0; j < 16; j++) begin
            drive(sq(j), 1'b1, 1'b0);
            tests++;
            if ({period_valid, hit, window_done} !== 3'b000) begin
                fails++;
                $display("FAIL idle_no_pulse j=%0d: pv=%b hit=%b wd=%b, want 0", j, period_valid, hit, window_done);
            end
        end
    endtask

    task automatic test_period();
        logic exp_pv;
        set_target(12'd8);
        k = 0;
        for (int j = 0; j < 64; j++) begin
            drive(sq(k), 1'b1, 1'b0);
            exp_pv = ((k % 8) == 0) && (k >= 8);
            tests++;
            if (period_valid !== exp_pv || hit !== exp_pv) begin
                fails++;
                $display("FAIL period_pulse k=%0d: pv=%b hit=%b, want %b", k, period_valid, hit, exp_pv);
            end
            if (exp_pv) begin
                tests++;
                if (period_out !== 12'd8) begin
                    fails++;
                    $display("FAIL period_value k=%0d: got %0d, want 8", k, period_out);
                end
            end
            k++;
        end
    endtask

    task automatic test_windows();
        logic exp_wd;
        while (k < 3072) begin
            drive(sq(k), 1'b1, 1'b0);
            exp_wd = ((k % 1024) == 1023);
            tests++;
            if (window_done !== exp_wd) begin
                fails++;
                $display("FAIL window_done k=%0d: got %b, want %b", k, window_done, exp_wd);
            end
            if (exp_wd) begin
                tests++;
                if (counter_val !== 32'((k + 1) / 1024)) begin
                    fails++;
                    $display("FAIL window_count k=%0d: got %0d, want %0d", k, counter_val, (k + 1) / 1024);
                end
            end
            k++;
        end
    endtask

    task automatic test_miss();
        logic exp_pv, exp_wd;
        set_target(12'd20);
        for (int j = 0; j < 1024; j++) begin
            drive(sq(j), 1'b1, 1'b0);
            exp_pv = ((j % 8) == 0) && (j >= 8);
            exp_wd = (j == 1023);
            tests++;
            if (period_valid !== exp_pv || hit !== 1'b0 || window_done !== exp_wd) begin
                fails++;
                $display("FAIL miss j=%0d: pv=%b hit=%b wd=%b, want pv=%b hit=0 wd=%b",
                         j, period_valid, hit, window_done, exp_pv, exp_wd);
            end
        end
        tests++;
        if (counter_val !== 32'd3) begin
            fails++;
            $display("FAIL miss_count: got %0d, want 3", counter_val);
        end
    endtask

    task automatic test_quiet();
        set_target(12'd8);
        for (int j = 0; j < 16; j++) drive(sq(j), 1'b1, 1'b0);
        for (int j = 0; j < 4200; j++) begin
            drive(quiet(j), 1'b1, 1'b0);
            tests++;
            if (period_valid !== 1'b0) begin
                fails++;
                $display("FAIL quiet_no_period j=%0d: pv=%b po=%0d, want pv 0", j, period_valid, period_out);
            end
        end
        for (int j = 0; j < 16; j++) begin
            drive(sq(j), 1'b1, 1'b0);
            if (j == 0) begin
                tests++;
                if (period_valid !== 1'b0) begin
                    fails++;
                    $display("FAIL rearm_first_crossing: pv=%b po=%0d, want pv 0", period_valid, period_out);
                end
            end
            if (j == 8) begin
                tests++;
                if (period_valid !== 1'b1 || period_out !== 12'd8) begin
                    fails++;
                    $display("FAIL rearm_second_crossing: pv=%b po=%0d, want pv 1 po 8", period_valid, period_out);
                end
            end
        end
        tests++;
        if (counter_val !== 32'd3) begin
            fails++;
            $display("FAIL quiet_count: got %0d, want 3", counter_val);
        end
    endtask

    task automatic test_tolerance();
        logic [11:0] tgts [4];
        logic        exps [4];
        tgts = '{12'd7, 12'd9, 12'd6, 12'd10};
        exps = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int t = 0; t < 4; t++) begin
            set_target(tgts[t]);
            for (int j = 0; j < 24; j++) begin
                drive(sq(j), 1'b1, 1'b0);
                if (j == 8 || j == 16) begin
                    tests++;
                    if (period_valid !== 1'b1 || hit !== exps[t]) begin
                        fails++;
                        $display("FAIL tol tgt=%0d j=%0d: pv=%b hit=%b, want pv 1 hit %b",
                                 tgts[t], j, period_valid, hit, exps[t]);
                    end
                end
            end
        end
    endtask

    task automatic test_target_change();
        set_target(12'd8);
        for (int j = 0; j < 512; j++) drive(sq(j), 1'b1, 1'b0);
        set_target(12'd12);
        for (int j = 0; j < 1024; j++) begin
            drive(sq(j), 1'b1, 1'b0);
            tests++;
            if (window_done !== (j == 1023)) begin
                fails++;
                $display("FAIL change_window j=%0d: wd=%b, want %b", j, window_done, (j == 1023));
            end
        end
        tests++;
        if (counter_val !== 32'd3) begin
            fails++;
            $display("FAIL change_count: got %0d, want 3", counter_val);
        end
    endtask

    task automatic test_clear_on_pass();
        set_target(12'd8);
        for (int j = 0; j < 1024; j++) drive(sq(j), 1'b1, (j == 1023));
        tests++;
        if (window_done !== 1'b1 || counter_val !== 32'd0) begin
            fails++;
            $display("FAIL clear_beats_pass: wd=%b cv=%0d, want wd 1 cv 0", window_done, counter_val);
        end
        for (int j = 0; j < 1024; j++) drive(sq(j), 1'b1, 1'b0);
        tests++;
        if (window_done !== 1'b1 || counter_val !== 32'd1) begin
            fails++;
            $display("FAIL pass_after_clear: wd=%b cv=%0d, want wd 1 cv 1", window_done, counter_val);
        end
    endtask

    task automatic test_reset_mid();
        for (int j = 0; j < 12; j++) drive(sq(j), 1'b1, 1'b0);
        reset = 1'b1;
        drive(sq(12), 1'b1, 1'b0);
        tests++;
        if ({counter_val, period_out, period_valid, hit, window_done} !== '0) begin
            fails++;
            $display("FAIL reset_mid: cv=%0d po=%0d pv=%b hit=%b wd=%b, want all 0",
                     counter_val, period_out, period_valid, hit, window_done);
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_period();
        test_windows();
        test_miss();
        test_quiet();
        test_tolerance();
        test_target_change();
        test_clear_on_pass();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
